demux_1to3_buffered: RTL

// - Write-side counterpart of the datapath 3:1 selector: steers one 8-bit source word to one of three sinks.
// - Selection uses the same 2-bit encoding: 0 -> sink A, 1 -> sink B, 2 and 3 -> sink C.
// - Sink C is 2 bits wide and receives the low 2 bits; the upper 6 bits are discarded.
// - Each sink has its own small FIFO with valid/ready handshakes, so a stalled sink does not block the

---
 rtl/demux_1to3_buffered_pkg.sv | 24 ++
 rtl/demux_1to3_buffered_fifo.sv | 95 +++++++++
 rtl/demux_1to3_buffered.sv | 76 +++++++
 3 files changed

// File: rtl/demux_1to3_buffered_pkg.sv
// Shared constants for the 1:3 buffered write-side demux: select encoding,
// data width and the select-to-push-enable decode.
package demux_1to3_buffered_pkg;

    localparam int         DW          = 8;
    localparam logic [1:0] SEL_A       = 2'd0;
    localparam logic [1:0] SEL_B       = 2'd1;
    localparam logic [1:0] SEL_C       = 2'd2;
    localparam logic [1:0] SEL_C_ALIAS = 2'd3;

    // One-hot sink enable: bit 0 = A, bit 1 = B, bit 2 = C.
    function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        case (sel)
            SEL_A:       oh = 3'b001;
            SEL_B:       oh = 3'b010;
            SEL_C:       oh = 3'b100;
            SEL_C_ALIAS: oh = 3'b100;
            default:     oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demux_1to3_buffered_fifo.sv
// Small synchronous FIFO with a registered head word that holds its last
// value once the FIFO drains.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  rdata_q, rdata_d;
    logic          push_en_s;
    logic          pop_en_s;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == {(AW+1){1'b0}});
    assign push_en_s = push & ~full;
    assign pop_en_s  = pop & ~empty;
    assign rdata     = rdata_q;

    // Next pointers, occupancy and head word.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        rdata_d = rdata_q;
        if (push_en_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_en_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_en_s, pop_en_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        // The new head is either already stored or is the word being written now.
        if (count_d != {(AW+1){1'b0}}) begin
            if (push_en_s && (rptr_d == wptr_q)) begin
                rdata_d = wdata;
            end else begin
                rdata_d = mem_q[rptr_d];
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Pointer, count and head registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            count_q <= {(AW+1){1'b0}};
            rdata_q <= {W{1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else if (push_en_s) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/demux_1to3_buffered.sv
// Steers one source word to sink A, B or C (low 2 bits only) through
// per-sink FIFOs so a stalled sink never blocks the others.
module demux_1to3_buffered
    import demux_1to3_buffered_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    in_sel,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] a_data,
    output logic          a_valid,
    input  logic          a_ready,
    output logic [DW-1:0] b_data,
    output logic          b_valid,
    input  logic          b_ready,
    output logic [1:0]    c_data,
    output logic          c_valid,
    input  logic          c_ready,
    output logic          busy
);

    logic [2:0] sel_oh_s;
    logic [2:0] full_s;
    logic [2:0] empty_s;
    logic [2:0] push_s;
    logic       accept_s;

    assign sel_oh_s = sel_onehot(in_sel);
    assign in_ready = ~|(sel_oh_s & full_s);
    assign accept_s = in_valid & in_ready;
    assign push_s   = sel_oh_s & {3{accept_s}};

    assign a_valid = ~empty_s[0];
    assign b_valid = ~empty_s[1];
    assign c_valid = ~empty_s[2];
    assign busy    = a_valid | b_valid | c_valid;

    sync_fifo #(.W(DW), .DEPTH(DEPTH), .AW(AW)) u_fifo_a (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s[0]),
        .wdata (in_data),
        .full  (full_s[0]),
        .pop   (a_valid & a_ready),
        .rdata (a_data),
        .empty (empty_s[0])
    );

    sync_fifo #(.W(DW), .DEPTH(DEPTH), .AW(AW)) u_fifo_b (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s[1]),
        .wdata (in_data),
        .full  (full_s[1]),
        .pop   (b_valid & b_ready),
        .rdata (b_data),
        .empty (empty_s[1])
    );

    sync_fifo #(.W(2), .DEPTH(DEPTH), .AW(AW)) u_fifo_c (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s[2]),
        .wdata (in_data[1:0]),
        .full  (full_s[2]),
        .pop   (c_valid & c_ready),
        .rdata (c_data),
        .empty (empty_s[2])
    );

endmodule
